// File: rtl/cp0_irq_timer_if.sv
// Bus bundle between the CP0 core / exception unit and cp0_irq_timer.
// Handshake: int_req stays high while a masked interrupt is pending; the exception unit pulses int_ack while int_req is high to take it.
interface cp0_irq_timer_if #(
    parameter int N_HW = 6
);
    logic              stall;
    logic              we;
    logic [4:0]        wr_addr;
    logic [2:0]        wr_sel;
    logic [31:0]       data_i;
    logic [4:0]        rd_addr;
    logic [2:0]        rd_sel;
    logic [31:0]       data_o;
    logic [N_HW-1:0]   hw_int_in;
    logic [7:0]        status_im;
    logic              status_ie;
    logic              status_exl;
    logic [7:0]        ip;
    logic              timer_int;
    logic              int_req;
    logic              int_ack;

    modport master (
        output stall, we, wr_addr, wr_sel, data_i, rd_addr, rd_sel,
        output hw_int_in, status_im, status_ie, status_exl, int_ack,
        input  data_o, ip, timer_int, int_req
    );

    modport slave (
        input  stall, we, wr_addr, wr_sel, data_i, rd_addr, rd_sel,
        input  hw_int_in, status_im, status_ie, status_exl, int_ack,
        output data_o, ip, timer_int, int_req
    );
endinterface

// File: rtl/cp0_irq_timer.sv
// CP0 interrupt/timer unit: Count/Compare timer, hw line sync, pending vector, request FSM.
// Define CP0_IRQ_LATCH_EN for edge-latched hw lines (readable / W1C at {13,1}); default is level mode.
module cp0_irq_timer #(
    parameter int N_HW        = 6,
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_DIV   = 2,
    parameter int TIMER_LINE  = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    cp0_irq_timer_if.slave         bus,
    output logic [1:0]             o_dbg_state
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] A_COUNT   = {5'd9,  3'd0};
    localparam logic [7:0] A_COMPARE = {5'd11, 3'd0};
    localparam logic [7:0] A_CAUSE   = {5'd13, 3'd0};
    localparam logic [7:0] A_LATCH   = {5'd13, 3'd1};
    localparam logic [3:0] DIV_LAST  = 4'(COUNT_DIV - 1);

    logic [31:0]     r_count;
    logic [31:0]     r_compare;
    logic            r_armed;
    logic [3:0]      r_presc;
    logic [1:0]      r_sw;
    logic            r_timer_int;
    logic [7:0]      r_ip;
    logic [N_HW-1:0] r_sync [SYNC_STAGES];
    state_t          r_state;
    state_t          w_next;

    logic            w_wr;
    logic [7:0]      w_wr_addr;
    logic [7:0]      w_rd_addr;
    logic [N_HW-1:0] w_sync;
    logic [N_HW-1:0] w_src;
    logic [31:0]     w_latch_rd;
    logic [5:0]      w_hw;
    logic            w_pend;
    logic            w_take;

    assign w_wr      = bus.we & bus.stall;
    assign w_wr_addr = {bus.wr_addr, bus.wr_sel};
    assign w_rd_addr = {bus.rd_addr, bus.rd_sel};

    // Prescaler and Count only advance while the pipeline runs; a Count write restarts the prescaler.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 32'd1;
            r_presc <= 4'd0;
        end else if (w_wr && w_wr_addr == A_COUNT) begin
            r_count <= bus.data_i;
            r_presc <= 4'd0;
        end else if (bus.stall) begin
            if (r_presc == DIV_LAST) begin
                r_presc <= 4'd0;
                r_count <= r_count + 32'd1;
            end else begin
                r_presc <= r_presc + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_compare   <= 32'd0;
            r_armed     <= 1'b0;
            r_timer_int <= 1'b0;
        end else if (w_wr && w_wr_addr == A_COMPARE) begin
            r_compare   <= bus.data_i;
            r_armed     <= 1'b1;
            r_timer_int <= 1'b0;
        end else if (r_armed && r_count == r_compare) begin
            r_timer_int <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sw <= 2'b00;
        end else if (w_wr && w_wr_addr == A_CAUSE) begin
            r_sw <= bus.data_i[9:8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
        end else begin
            r_sync[0] <= bus.hw_int_in;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef CP0_IRQ_LATCH_EN
    logic [N_HW-1:0] r_sync_d;
    logic [N_HW-1:0] r_latch;
    logic [N_HW-1:0] w_edge;
    logic [N_HW-1:0] w_clr;

    assign w_edge = w_sync & ~r_sync_d;
    assign w_clr  = (w_wr && w_wr_addr == A_LATCH) ? bus.data_i[N_HW-1:0] : '0;

    // A rising edge in the clear cycle wins so no interrupt is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_d <= '0;
            r_latch  <= '0;
        end else begin
            r_sync_d <= w_sync;
            r_latch  <= (r_latch & ~w_clr) | w_edge;
        end
    end

    assign w_src      = r_latch;
    assign w_latch_rd = 32'(r_latch);
`else
    assign w_src      = w_sync;
    assign w_latch_rd = 32'd0;
`endif

    always_comb begin
        w_hw = 6'd0;
        for (int i = 0; i < N_HW; i++) w_hw[i] = w_src[i];
        w_hw[TIMER_LINE] = w_hw[TIMER_LINE] | r_timer_int;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ip <= 8'd0;
        else     r_ip <= {w_hw, r_sw};
    end

    always_comb begin
        bus.data_o = 32'd0;
        case (w_rd_addr)
            A_COUNT:   bus.data_o = r_count;
            A_COMPARE: bus.data_o = r_compare;
            A_CAUSE:   bus.data_o = {16'd0, r_ip, 8'd0};
            A_LATCH:   bus.data_o = w_latch_rd;
            default:   bus.data_o = 32'd0;
        endcase
    end

    assign w_pend = |(r_ip & bus.status_im);
    assign w_take = bus.stall & bus.status_ie & ~bus.status_exl & w_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // A vanished pending term withdraws the request even if ack arrives in the same cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_take) w_next = ST_REQ;
            ST_REQ: begin
                if (!w_pend)          w_next = ST_IDLE;
                else if (bus.int_ack) w_next = ST_WAIT;
            end
            ST_WAIT: if (!bus.status_exl) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.int_req = (r_state == ST_REQ) && w_pend;
    end

    assign bus.ip        = r_ip;
    assign bus.timer_int = r_timer_int;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_cp0_irq_timer.sv
// Directed bench for cp0_irq_timer with default parameters (N_HW=6, SYNC_STAGES=2, COUNT_DIV=2, TIMER_LINE=5).
module tb_cp0_irq_timer;
    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         n_tests;
    int         n_fail;

    cp0_irq_timer_if #(.N_HW(6)) bus_if ();

    cp0_irq_timer #(
        .N_HW(6), .SYNC_STAGES(2), .COUNT_DIV(2), .TIMER_LINE(5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cp0_wr(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
        bus_if.we      = 1'b1;
        bus_if.wr_addr = a;
        bus_if.wr_sel  = s;
        bus_if.data_i  = d;
        step(1);
        bus_if.we      = 1'b0;
    endtask

    task automatic rd_check(input logic [4:0] a, input logic [2:0] s, input string tag, input logic [31:0] exp_v);
        bus_if.rd_addr = a;
        bus_if.rd_sel  = s;
        #1;
        check(tag, bus_if.data_o, exp_v);
    endtask

    initial begin
        n_tests           = 0;
        n_fail            = 0;
        rst               = 1'b0;
        bus_if.stall      = 1'b0;
        bus_if.we         = 1'b0;
        bus_if.wr_addr    = 5'd0;
        bus_if.wr_sel     = 3'd0;
        bus_if.data_i     = 32'd0;
        bus_if.rd_addr    = 5'd0;
        bus_if.rd_sel     = 3'd0;
        bus_if.hw_int_in  = 6'd0;
        bus_if.status_im  = 8'd0;
        bus_if.status_ie  = 1'b0;
        bus_if.status_exl = 1'b0;
        bus_if.int_ack    = 1'b0;

        // 1: async reset asserted before any clock edge
        #3 rst = 1'b1;
        #1;
        check("rst_int_req", 32'(bus_if.int_req), 32'd0);
        check("rst_ip", 32'(bus_if.ip), 32'd0);
        check("rst_timer_int", 32'(bus_if.timer_int), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_data_o", bus_if.data_o, 32'd0);
        rd_check(5'd9, 3'd0, "rst_count", 32'd1);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        step(1);
        rd_check(5'd9, 3'd0, "post_rst_count", 32'd1);
        check("post_rst_int_req", 32'(bus_if.int_req), 32'd0);

        // 2: Count wrap and freeze under stall=0
        bus_if.stall = 1'b1;
        cp0_wr(5'd9, 3'd0, 32'hFFFF_FFFE);
        step(4);
        bus_if.stall = 1'b0;
        rd_check(5'd9, 3'd0, "count_wrap", 32'h0000_0000);
        step(5);
        rd_check(5'd9, 3'd0, "count_hold", 32'h0000_0000);

        // 3: Compare match, timer onto IP[7], clear on Compare write
        bus_if.stall = 1'b1;
        cp0_wr(5'd11, 3'd0, 32'h0000_0010);
        cp0_wr(5'd9, 3'd0, 32'h0000_000E);
        step(4);
        check("timer_not_yet", 32'(bus_if.timer_int), 32'd0);
        step(1);
        check("timer_set", 32'(bus_if.timer_int), 32'd1);
        step(1);
        check("timer_ip7", 32'(bus_if.ip), 32'h80);
        rd_check(5'd13, 3'd0, "cause_read_ip7", 32'h0000_8000);
        cp0_wr(5'd11, 3'd0, 32'hFFFF_0000);
        check("timer_cleared", 32'(bus_if.timer_int), 32'd0);
        rd_check(5'd11, 3'd0, "compare_read", 32'hFFFF_0000);
        step(1);
        check("timer_ip7_clear", 32'(bus_if.ip), 32'h00);

        // 4: hw line 2 -> IP[4], request, ack, WAIT until EXL drops
        bus_if.hw_int_in  = 6'b000100;
        bus_if.status_im  = 8'h10;
        bus_if.status_ie  = 1'b1;
        bus_if.status_exl = 1'b0;
        step(3);
        check("hw_req_early", 32'(bus_if.int_req), 32'd0);
        step(1);
        check("hw_req", 32'(bus_if.int_req), 32'd1);
        check("hw_ip", 32'(bus_if.ip), 32'h10);
        check("hw_state_req", 32'(dbg_state), 32'd1);
        bus_if.int_ack    = 1'b1;
        bus_if.status_exl = 1'b1;
        step(1);
        bus_if.int_ack = 1'b0;
        check("ack_req_low", 32'(bus_if.int_req), 32'd0);
        check("ack_state_wait", 32'(dbg_state), 32'd2);
        step(3);
        check("wait_hold", 32'(dbg_state), 32'd2);
        bus_if.status_exl = 1'b0;
        step(1);
        check("wait_to_idle", 32'(dbg_state), 32'd0);
        bus_if.hw_int_in = 6'd0;
        bus_if.status_ie = 1'b0;
        bus_if.status_im = 8'h00;
        step(4);
        check("hw_ip_clear", 32'(bus_if.ip), 32'h00);
        check("hw_idle", 32'(dbg_state), 32'd0);

        // 5: software interrupt, request withdrawn when IM clears
        bus_if.status_im = 8'h01;
        bus_if.status_ie = 1'b1;
        cp0_wr(5'd13, 3'd0, 32'h0000_0100);
        check("sw_ip_lag", 32'(bus_if.ip), 32'h00);
        step(1);
        check("sw_ip", 32'(bus_if.ip), 32'h01);
        check("sw_req_early", 32'(bus_if.int_req), 32'd0);
        step(1);
        check("sw_req", 32'(bus_if.int_req), 32'd1);
        bus_if.status_im = 8'h00;
        #1;
        check("sw_req_drop_same_cycle", 32'(bus_if.int_req), 32'd0);
        step(1);
        check("sw_back_idle", 32'(dbg_state), 32'd0);
        bus_if.status_ie = 1'b0;
        cp0_wr(5'd13, 3'd0, 32'h0000_0000);
        step(1);
        check("sw_ip_clear", 32'(bus_if.ip), 32'h00);

        // 6: one-cycle pulse on hw line 0, then the {13,1} register
        bus_if.hw_int_in = 6'b000001;
        step(1);
        bus_if.hw_int_in = 6'b000000;
        step(3);
`ifdef CP0_IRQ_LATCH_EN
        rd_check(5'd13, 3'd1, "latch_set", 32'h0000_0001);
        check("latch_ip2", 32'(bus_if.ip), 32'h04);
        cp0_wr(5'd13, 3'd1, 32'h0000_0001);
        rd_check(5'd13, 3'd1, "latch_w1c", 32'h0000_0000);
        step(1);
        check("latch_ip2_clear", 32'(bus_if.ip), 32'h00);
`else
        rd_check(5'd13, 3'd1, "level_latch_reads0", 32'h0000_0000);
        check("level_ip_after_pulse", 32'(bus_if.ip), 32'h00);
        cp0_wr(5'd13, 3'd1, 32'hFFFF_FFFF);
        rd_check(5'd13, 3'd1, "level_latch_write_ignored", 32'h0000_0000);
`endif
        rd_check(5'd1, 3'd0, "unmapped_read", 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
